// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the parametrised up/down counter family.
//   CNT_WRAP / CNT_SAT : values for the SATURATE parameter
//   mod_is_legal()     : parameter legality check used at elaboration
//   clamp_load()       : limits a load value to the top of the count range
// ---------------------------------------------------------------------------
package counter_pkg;

    // Boundary behaviour selectors for the SATURATE parameter
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // A counter needs at least two states, and the modulus must fit in the
    // register width. Widths of 31 and above can hold any positive int modulus.
    function automatic bit mod_is_legal(input int width, input int mod);
        if (width < 1) return 1'b0;
        if (mod < 2) return 1'b0;
        if (width >= 31) return 1'b1;
        return (mod <= (1 << width));
    endfunction

    // Loads above the top of the range are pinned to MOD-1 so the counter can
    // never hold a value outside 0..MOD-1.
    function automatic logic [63:0] clamp_load(input logic [63:0] value, input int mod);
        logic [63:0] top;
        top = 64'(mod - 1);
        if (value > top) return top;
        return value;
    endfunction

endpackage

// File: rtl/counter_next_state.sv
// ---------------------------------------------------------------------------
// counter_next_state
// Combinational step function of the up/down counter.
//   count        in  : current count
//   up           in  : 1 = increment, 0 = decrement
//   en           in  : step enable; when low the count is passed through
//   next_count   out : count after one enabled step
//   boundary_hit out : the step crossed MOD-1 (up) or 0 (down)
// Parameters MOD and SATURATE select the range and the boundary behaviour.
// ---------------------------------------------------------------------------
module counter_next_state
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] next_count,
    output logic             boundary_hit
);

    // Top of the range, held one bit wider so MOD == 2**WIDTH still fits
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MOD - 1);

    logic [WIDTH:0] countExt;
    logic [WIDTH:0] incExt;
    logic [WIDTH:0] decExt;

    // The step is worked out one bit wider than the count. An increment that
    // passes MAX_EXT, or a decrement that borrows into the extra bit, is a
    // boundary event; the low bits are then never used as the result, so a
    // value >= MOD can never be produced by truncation.
    always_comb begin
        countExt     = {1'b0, count};
        incExt       = countExt + 1'b1;
        decExt       = countExt - 1'b1;
        next_count   = count;
        boundary_hit = 1'b0;
        if (en) begin
            if (up) begin
                if (incExt > MAX_EXT) begin
                    boundary_hit = 1'b1;
                    next_count   = (SATURATE == CNT_SAT) ? count : '0;
                end else begin
                    next_count = incExt[WIDTH-1:0];
                end
            end else begin
                if (decExt[WIDTH]) begin
                    boundary_hit = 1'b1;
                    next_count   = (SATURATE == CNT_SAT) ? count : MAX_EXT[WIDTH-1:0];
                end else begin
                    next_count = decExt[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// ---------------------------------------------------------------------------
// updown_counter_n
// WIDTH-bit up/down counter with modulus MOD, wrap or saturate at the bounds,
// synchronous clear/load/enable, terminal-count pulse and sticky overflow.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset
//   clr      in  : clear count to 0
//   load     in  : load load_val (clamped to MOD-1)
//   load_val in  : value to load
//   en       in  : count enable
//   up       in  : 1 = count up, 0 = count down
//   ovf_clr  in  : clear the sticky overflow flag
//   count    out : registered count
//   tc       out : registered one-cycle terminal-count pulse
//   ovf      out : registered sticky overflow/underflow flag
//   at_max   out : count == MOD-1
//   at_zero  out : count == 0
// Priority at each edge: rst > clr > load > en.
// ---------------------------------------------------------------------------
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MOD      = 16,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    // Stop elaboration on a modulus that cannot be represented
    if (!mod_is_legal(WIDTH, MOD)) begin : g_illegalParams
        $fatal(1, "updown_counter_n: MOD must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] nextCount;
    logic             boundaryHit;
    logic [WIDTH-1:0] loadClamped;
    logic             stepTaken;

    counter_next_state #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .SATURATE (SATURATE)
    ) u_nextState (
        .count        (count_q),
        .up           (up),
        .en           (en),
        .next_count   (nextCount),
        .boundary_hit (boundaryHit)
    );

    // Out-of-range loads are pinned to the top of the count range
    always_comb begin
        loadClamped = WIDTH'(clamp_load(64'(load_val), MOD));
    end

    // Next-state selection in priority order clr > load > en. A step only
    // happens when neither clr nor load claims the cycle, and only a step can
    // raise tc or set ovf. ovf_clr is honoured unless a boundary event sets
    // the flag on the same edge.
    always_comb begin
        stepTaken = !clr && !load && en;
        count_d   = count_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = loadClamped;
        end else if (en) begin
            count_d = nextCount;
            tc_d    = boundaryHit;
        end
        if (stepTaken && boundaryHit) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers; reset wins over every other input on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from the registers; the range flags decode them
    always_comb begin
        count   = count_q;
        tc      = tc_q;
        ovf     = ovf_q;
        at_max  = (count_q == MAX_CNT);
        at_zero = (count_q == '0);
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_n
// Three counters share one set of inputs:
//   d0 : WIDTH=4, MOD=10, wrap
//   d1 : WIDTH=4, MOD=10, saturate
//   d2 : WIDTH=4, MOD=16, wrap (natural binary roll-over)
// Expected values for d0 in the vector table are written out by hand; every
// other expectation comes from a small behavioural model. Expectations are
// queued when a cycle is driven and popped once the edge has happened.
// ---------------------------------------------------------------------------
module tb_updown_counter_n;

    localparam int WIDTH = 4;
    localparam int NDUT  = 3;

    typedef struct {
        bit       rst;
        bit       clr;
        bit       load;
        int       loadVal;
        bit       en;
        bit       up;
        bit       ovfClr;
        int       expCount;
        bit       expTc;
        bit       expOvf;
    } vec_t;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, clr, load, en, up, ovfClr;
    logic [WIDTH-1:0] loadVal;
    logic [WIDTH-1:0] dCount [NDUT];
    logic             dTc    [NDUT];
    logic             dOvf   [NDUT];
    logic             dAtMax [NDUT];
    logic             dAtZero[NDUT];

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    int   modTab[NDUT];
    bit   satTab[NDUT];
    int   mCount[NDUT];
    bit   mTc[NDUT];
    bit   mOvf[NDUT];
    vec_t vecs[$];

    // Free-running clock
    always #5 clk = ~clk;

    updown_counter_n #(.WIDTH(WIDTH), .MOD(10), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(loadVal),
        .en(en), .up(up), .ovf_clr(ovfClr), .count(dCount[0]), .tc(dTc[0]),
        .ovf(dOvf[0]), .at_max(dAtMax[0]), .at_zero(dAtZero[0]));

    updown_counter_n #(.WIDTH(WIDTH), .MOD(10), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(loadVal),
        .en(en), .up(up), .ovf_clr(ovfClr), .count(dCount[1]), .tc(dTc[1]),
        .ovf(dOvf[1]), .at_max(dAtMax[1]), .at_zero(dAtZero[1]));

    updown_counter_n #(.WIDTH(WIDTH), .MOD(16), .SATURATE(0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(loadVal),
        .en(en), .up(up), .ovf_clr(ovfClr), .count(dCount[2]), .tc(dTc[2]),
        .ovf(dOvf[2]), .at_max(dAtMax[2]), .at_zero(dAtZero[2]));

    // Single comparison with a FAIL line on disagreement
    task automatic compare(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Behavioural reference: one clock edge of counter i
    task automatic modelStep(input int i);
        bit hit;
        hit = 1'b0;
        if (rst) begin
            mCount[i] = 0;
            mTc[i]    = 1'b0;
            mOvf[i]   = 1'b0;
        end else begin
            if (clr) begin
                mCount[i] = 0;
            end else if (load) begin
                mCount[i] = (int'(loadVal) > modTab[i] - 1) ? modTab[i] - 1 : int'(loadVal);
            end else if (en && up) begin
                if (mCount[i] == modTab[i] - 1) begin
                    hit = 1'b1;
                    if (!satTab[i]) mCount[i] = 0;
                end else begin
                    mCount[i] = mCount[i] + 1;
                end
            end else if (en) begin
                if (mCount[i] == 0) begin
                    hit = 1'b1;
                    if (!satTab[i]) mCount[i] = modTab[i] - 1;
                end else begin
                    mCount[i] = mCount[i] - 1;
                end
            end
            mTc[i] = hit;
            if (hit) mOvf[i] = 1'b1;
            else if (ovfClr) mOvf[i] = 1'b0;
        end
    endtask

    // Pops one expectation per counter and compares all outputs
    task automatic checkOutput(input string tag);
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            if (expQ.size() == 0) begin
                compare($sformatf("%s.d%0d.queue_empty", tag, i), 1, 0);
            end else begin
                e = expQ.pop_front();
                compare($sformatf("%s.d%0d.count", tag, i), int'(dCount[i]), e.cnt);
                compare($sformatf("%s.d%0d.tc", tag, i), int'(dTc[i]), int'(e.tc));
                compare($sformatf("%s.d%0d.ovf", tag, i), int'(dOvf[i]), int'(e.ovf));
                compare($sformatf("%s.d%0d.at_max", tag, i), int'(dAtMax[i]),
                        int'(e.cnt == modTab[i] - 1));
                compare($sformatf("%s.d%0d.at_zero", tag, i), int'(dAtZero[i]),
                        int'(e.cnt == 0));
            end
        end
    endtask

    // Drives one cycle, queues expectations, then checks after the edge.
    // When useTable is set, d0 is checked against the hand-written values.
    task automatic applyStimulus(input vec_t v, input bit useTable, input string tag);
        exp_t e;
        @(negedge clk);
        rst     = v.rst;
        clr     = v.clr;
        load    = v.load;
        loadVal = WIDTH'(v.loadVal);
        en      = v.en;
        up      = v.up;
        ovfClr  = v.ovfClr;
        for (int i = 0; i < NDUT; i++) begin
            modelStep(i);
            e.cnt = mCount[i];
            e.tc  = mTc[i];
            e.ovf = mOvf[i];
            if (i == 0 && useTable) begin
                e.cnt = v.expCount;
                e.tc  = v.expTc;
                e.ovf = v.expOvf;
            end
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Convenience wrapper for model-only cycles
    task automatic cycle(input bit r, input bit c, input bit l, input int lv,
                         input bit e, input bit u, input bit oc, input string tag);
        vec_t v;
        v = '{r, c, l, lv, e, u, oc, 0, 1'b0, 1'b0};
        applyStimulus(v, 1'b0, tag);
    endtask

    // Table entry helper: inputs first, then d0 expectations
    function automatic vec_t mk(input bit r, input bit c, input bit l, input int lv,
                                input bit e, input bit u, input bit oc,
                                input int ec, input bit et, input bit eo);
        vec_t v;
        v = '{r, c, l, lv, e, u, oc, ec, et, eo};
        return v;
    endfunction

    initial begin
        modTab = '{10, 10, 16};
        satTab = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < NDUT; i++) begin
            mCount[i] = 0;
            mTc[i]    = 1'b0;
            mOvf[i]   = 1'b0;
        end
        rst = 1'b1; clr = 1'b0; load = 1'b0; loadVal = '0;
        en = 1'b0; up = 1'b0; ovfClr = 1'b0;

        // Vector table for the MOD=10 wrap counter
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0, 0,0,0));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0,0,0,0, 1,1,0, k,0,0));
        vecs.push_back(mk(0,0,0,0, 1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0, 1,1,0, 1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,1,0, 2,0,1));
        vecs.push_back(mk(0,0,1,3, 0,0,0, 3,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0,0, 2,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0,0, 1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0,0, 0,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0,0, 9,1,1));
        vecs.push_back(mk(0,0,0,0, 1,0,0, 8,0,1));
        vecs.push_back(mk(0,0,1,15, 0,0,0, 9,0,1));
        vecs.push_back(mk(0,0,1,4, 1,1,0, 4,0,1));
        vecs.push_back(mk(0,1,1,7, 1,1,0, 0,0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,0,1, 9,1,1));
        vecs.push_back(mk(0,0,0,0, 1,1,0, 0,1,1));
        vecs.push_back(mk(0,0,0,0, 0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,1,0, 0,0,0));

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k], 1'b1, $sformatf("vec%0d", k));
        end

        // Saturation at the top: load 8 then four up steps
        cycle(0,0,1,8, 0,0,1, "satLoad");
        for (int k = 0; k < 4; k++) cycle(0,0,0,0, 1,1,0, $sformatf("satUp%0d", k));
        compare("satHold.count", int'(dCount[1]), 9);
        compare("satHold.tc", int'(dTc[1]), 1);
        compare("satHold.ovf", int'(dOvf[1]), 1);
        compare("satHold.at_max", int'(dAtMax[1]), 1);

        // Saturation at the bottom, then ovf_clr without a boundary event
        cycle(0,1,0,0, 0,0,0, "satClr");
        cycle(0,0,0,0, 1,0,0, "satDown0");
        cycle(0,0,0,0, 1,0,0, "satDown1");
        cycle(0,0,0,0, 0,0,1, "satOvfClr");

        // Reset in the middle of counting, then resume
        cycle(0,1,0,0, 0,0,0, "rstPrep");
        for (int k = 0; k < 5; k++) cycle(0,0,0,0, 1,1,0, $sformatf("rstCount%0d", k));
        compare("rstPrep.d0.count", int'(dCount[0]), 5);
        cycle(1,0,0,0, 1,1,0, "rstMid");
        compare("rstMid.d0.count", int'(dCount[0]), 0);
        cycle(0,0,0,0, 1,1,0, "rstResume");
        compare("rstResume.d0.count", int'(dCount[0]), 1);

        // Full binary roll-over on the MOD=16 counter
        cycle(0,0,1,14, 0,0,1, "rollLoad");
        for (int k = 0; k < 3; k++) cycle(0,0,0,0, 1,1,0, $sformatf("rollUp%0d", k));
        compare("roll.d2.count", int'(dCount[2]), 1);
        cycle(0,0,1,1, 0,0,0, "rollLoad1");
        for (int k = 0; k < 3; k++) cycle(0,0,0,0, 1,0,0, $sformatf("rollDown%0d", k));
        compare("roll.d2.countDown", int'(dCount[2]), 14);

        // Random mix of all controls against the model
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom_range(49) == 0), ($urandom_range(19) == 0),
                  ($urandom_range(9) == 0), int'($urandom_range(15)),
                  ($urandom_range(3) != 0), ($urandom_range(1) == 1),
                  ($urandom_range(7) == 0), $sformatf("rand%0d", k));
        end

        compare("queue.drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
